// File: rtl/usb_warmboot_sequencer.sv
// usb_warmboot_sequencer
//
// Sits between the bootloader and the SB_WARMBOOT / SB_IO primitives. It accepts
// an image-select request, or raises one itself after an idle timeout. It then
// holds the USB pair in SE0 long enough for the host to see a clean detach.
// After a short select setup time it pulses SB_WARMBOOT BOOT, and holds it until
// reset while the device reconfigures.
//
// Ports:
//   clk_usb        48 MHz system clock
//   reset          synchronous active-high reset
//   boot_req       single-cycle boot request, honoured only in IDLE
//   boot_image     image select, sampled together with boot_req
//   activity       any-cycle pulse that restarts the autoboot timer
//   boot_busy      high while detaching, settling or booting
//   boot_err       one-cycle pulse when a request names an out-of-range image
//   usb_detach     high: board top forces SE0 on the USB pair
//   warmboot_s     SB_WARMBOOT {S1,S0}
//   warmboot_boot  SB_WARMBOOT BOOT
`timescale 1ns/1ps

module usb_warmboot_sequencer #(
    parameter int NUM_IMAGES      = 4,
    parameter int DEFAULT_IMAGE   = 1,
    parameter int DETACH_CYCLES   = 480000,
    parameter int SETTLE_CYCLES   = 4,
    parameter int AUTOBOOT_CYCLES = 0
) (
    input  logic       clk_usb,
    input  logic       reset,
    input  logic       boot_req,
    input  logic [1:0] boot_image,
    input  logic       activity,
    output logic       boot_busy,
    output logic       boot_err,
    output logic       usb_detach,
    output logic [1:0] warmboot_s,
    output logic       warmboot_boot
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DETACH = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_BOOT   = 2'd3;

    localparam int DW = $clog2(DETACH_CYCLES > 2 ? DETACH_CYCLES : 2);
    localparam int SW = $clog2(SETTLE_CYCLES > 2 ? SETTLE_CYCLES : 2);
    localparam int CW = (DW > SW) ? DW : SW;
    localparam int AW = $clog2(AUTOBOOT_CYCLES > 2 ? AUTOBOOT_CYCLES : 2);

    // Detach and settle share one down-counter; each phase ends when it reads zero.
    localparam logic [CW-1:0] D_LAST = CW'(DETACH_CYCLES - 1);
    localparam logic [CW-1:0] S_LAST = CW'(SETTLE_CYCLES - 1);

    localparam bit            AB_EN   = (AUTOBOOT_CYCLES > 0);
    localparam logic [AW-1:0] AB_LAST = AB_EN ? AW'(AUTOBOOT_CYCLES - 1) : '0;

    localparam logic [1:0] DEF_S = 2'(DEFAULT_IMAGE);
    localparam logic [2:0] NUM_L = 3'(NUM_IMAGES);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] ab_cnt;
    logic          image_ok;
    logic          ab_expire;

    assign image_ok  = ({1'b0, boot_image} < NUM_L);
    assign ab_expire = AB_EN && (ab_cnt == AB_LAST);

    always_ff @(posedge clk_usb) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            ab_cnt        <= '0;
            boot_busy     <= 1'b0;
            boot_err      <= 1'b0;
            usb_detach    <= 1'b0;
            warmboot_s    <= DEF_S;
            warmboot_boot <= 1'b0;
        end else begin
            boot_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Priority: request (even a rejected one), then activity, then expiry.
                    if (boot_req) begin
                        ab_cnt <= '0;
                        if (image_ok) begin
                            warmboot_s <= boot_image;
                            state      <= ST_DETACH;
                            cnt        <= D_LAST;
                            usb_detach <= 1'b1;
                            boot_busy  <= 1'b1;
                        end else begin
                            boot_err <= 1'b1;
                        end
                    end else if (activity) begin
                        ab_cnt <= '0;
                    end else if (ab_expire) begin
                        ab_cnt     <= '0;
                        warmboot_s <= DEF_S;
                        state      <= ST_DETACH;
                        cnt        <= D_LAST;
                        usb_detach <= 1'b1;
                        boot_busy  <= 1'b1;
                    end else if (AB_EN) begin
                        ab_cnt <= ab_cnt + 1'b1;
                    end
                end
                ST_DETACH: begin
                    if (cnt == '0) begin
                        state <= ST_SETTLE;
                        cnt   <= S_LAST;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        state         <= ST_BOOT;
                        warmboot_boot <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_BOOT: begin
                    // Held until reset; the FPGA reconfigures underneath us.
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_warmboot_sequencer.sv
// Directed testbench for usb_warmboot_sequencer
// (NUM_IMAGES=3, DEFAULT_IMAGE=1, DETACH_CYCLES=8, SETTLE_CYCLES=2, AUTOBOOT_CYCLES=20).
`timescale 1ns/1ps

module tb_usb_warmboot_sequencer;

    logic       clk_usb = 1'b0;
    logic       reset = 1'b1;
    logic       boot_req = 1'b0;
    logic [1:0] boot_image = 2'd0;
    logic       activity = 1'b0;
    logic       boot_busy;
    logic       boot_err;
    logic       usb_detach;
    logic [1:0] warmboot_s;
    logic       warmboot_boot;

    int errors = 0;
    int checks = 0;

    usb_warmboot_sequencer #(
        .NUM_IMAGES      (3),
        .DEFAULT_IMAGE   (1),
        .DETACH_CYCLES   (8),
        .SETTLE_CYCLES   (2),
        .AUTOBOOT_CYCLES (20)
    ) dut (
        .clk_usb       (clk_usb),
        .reset         (reset),
        .boot_req      (boot_req),
        .boot_image    (boot_image),
        .activity      (activity),
        .boot_busy     (boot_busy),
        .boot_err      (boot_err),
        .usb_detach    (usb_detach),
        .warmboot_s    (warmboot_s),
        .warmboot_boot (warmboot_boot)
    );

    always #5 clk_usb = ~clk_usb;

    task automatic tick;
        @(posedge clk_usb);
        #1;
    endtask

    task automatic do_reset(input logic act);
        reset      = 1'b1;
        boot_req   = 1'b0;
        boot_image = 2'd0;
        activity   = act;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset(1'b1);
        checks++;
        if (boot_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", boot_busy); end
        checks++;
        if (boot_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", boot_err); end
        checks++;
        if (usb_detach !== 1'b0) begin errors++; $display("FAIL reset_detach: got %b expected 0", usb_detach); end
        checks++;
        if (warmboot_boot !== 1'b0) begin errors++; $display("FAIL reset_boot: got %b expected 0", warmboot_boot); end
        checks++;
        if (warmboot_s !== 2'd1) begin errors++; $display("FAIL reset_s: got %0d expected 1", warmboot_s); end
    endtask

    task automatic test_normal_boot;
        do_reset(1'b1);
        repeat (3) tick;
        boot_req = 1'b1; boot_image = 2'd2;
        tick;
        boot_req = 1'b0; boot_image = 2'd0;
        for (int i = 1; i <= 10; i++) begin
            checks++;
            if (usb_detach !== 1'b1 || warmboot_boot !== 1'b0 || warmboot_s !== 2'd2 || boot_busy !== 1'b1) begin
                errors++;
                $display("FAIL normal_seq cyc+%0d: detach=%b boot=%b s=%0d busy=%b expected 1/0/2/1",
                         i, usb_detach, warmboot_boot, warmboot_s, boot_busy);
            end
            tick;
        end
        checks++;
        if (warmboot_boot !== 1'b1 || usb_detach !== 1'b1 || warmboot_s !== 2'd2) begin
            errors++;
            $display("FAIL normal_boot_rise: boot=%b detach=%b s=%0d expected 1/1/2", warmboot_boot, usb_detach, warmboot_s);
        end
        repeat (5) tick;
        checks++;
        if (warmboot_boot !== 1'b1 || usb_detach !== 1'b1) begin
            errors++;
            $display("FAIL normal_boot_hold: boot=%b detach=%b expected 1/1", warmboot_boot, usb_detach);
        end
    endtask

    task automatic test_bad_image;
        do_reset(1'b1);
        repeat (2) tick;
        boot_req = 1'b1; boot_image = 2'd3;
        tick;
        boot_req = 1'b0; boot_image = 2'd0;
        checks++;
        if (boot_err !== 1'b1 || usb_detach !== 1'b0 || boot_busy !== 1'b0 || warmboot_s !== 2'd1) begin
            errors++;
            $display("FAIL bad_image_pulse: err=%b detach=%b busy=%b s=%0d expected 1/0/0/1",
                     boot_err, usb_detach, boot_busy, warmboot_s);
        end
        tick;
        checks++;
        if (boot_err !== 1'b0 || usb_detach !== 1'b0 || boot_busy !== 1'b0 || warmboot_s !== 2'd1) begin
            errors++;
            $display("FAIL bad_image_after: err=%b detach=%b busy=%b s=%0d expected 0/0/0/1",
                     boot_err, usb_detach, boot_busy, warmboot_s);
        end
        boot_req = 1'b1; boot_image = 2'd0;
        tick;
        boot_req = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            checks++;
            if (usb_detach !== 1'b1 || warmboot_boot !== 1'b0 || warmboot_s !== 2'd0 || boot_err !== 1'b0) begin
                errors++;
                $display("FAIL bad_then_good cyc+%0d: detach=%b boot=%b s=%0d err=%b expected 1/0/0/0",
                         i, usb_detach, warmboot_boot, warmboot_s, boot_err);
            end
            tick;
        end
        checks++;
        if (warmboot_boot !== 1'b1) begin errors++; $display("FAIL bad_then_good_boot: got %b expected 1", warmboot_boot); end
    endtask

    task automatic test_autoboot;
        do_reset(1'b0);
        for (int k = 1; k <= 19; k++) begin
            tick;
            checks++;
            if (usb_detach !== 1'b0 || boot_busy !== 1'b0) begin
                errors++;
                $display("FAIL autoboot_early cyc%0d: detach=%b busy=%b expected 0/0", k, usb_detach, boot_busy);
            end
        end
        tick;
        checks++;
        if (usb_detach !== 1'b1 || warmboot_s !== 2'd1 || warmboot_boot !== 1'b0) begin
            errors++;
            $display("FAIL autoboot_detach: detach=%b s=%0d boot=%b expected 1/1/0", usb_detach, warmboot_s, warmboot_boot);
        end
        for (int k = 21; k <= 29; k++) begin
            tick;
            checks++;
            if (warmboot_boot !== 1'b0 || usb_detach !== 1'b1) begin
                errors++;
                $display("FAIL autoboot_seq cyc%0d: boot=%b detach=%b expected 0/1", k, warmboot_boot, usb_detach);
            end
        end
        tick;
        checks++;
        if (warmboot_boot !== 1'b1) begin errors++; $display("FAIL autoboot_boot: got %b expected 1", warmboot_boot); end
    endtask

    task automatic test_activity_refresh;
        logic seen_busy;
        do_reset(1'b0);
        seen_busy = 1'b0;
        for (int c = 0; c < 500; c++) begin
            activity = ((c % 15) == 14);
            tick;
            if (boot_busy !== 1'b0 || usb_detach !== 1'b0) seen_busy = 1'b1;
        end
        activity = 1'b0;
        checks++;
        if (seen_busy !== 1'b0) begin errors++; $display("FAIL activity_refresh: busy_seen=%b expected 0", seen_busy); end

        // Activity exactly on the expiry cycle.
        do_reset(1'b0);
        repeat (19) tick;
        activity = 1'b1;
        tick;
        activity = 1'b0;
        checks++;
        if (usb_detach !== 1'b0 || boot_busy !== 1'b0) begin
            errors++;
            $display("FAIL activity_at_expiry: detach=%b busy=%b expected 0/0", usb_detach, boot_busy);
        end
        // Counter restarted; request on the next expiry cycle wins.
        repeat (19) tick;
        boot_req = 1'b1; boot_image = 2'd2;
        tick;
        boot_req = 1'b0; boot_image = 2'd0;
        checks++;
        if (usb_detach !== 1'b1 || warmboot_s !== 2'd2 || boot_busy !== 1'b1) begin
            errors++;
            $display("FAIL req_at_expiry: detach=%b s=%0d busy=%b expected 1/2/1", usb_detach, warmboot_s, boot_busy);
        end

        // Rejected request on the expiry cycle also restarts the timer.
        do_reset(1'b0);
        repeat (19) tick;
        boot_req = 1'b1; boot_image = 2'd3;
        tick;
        boot_req = 1'b0; boot_image = 2'd0;
        checks++;
        if (boot_err !== 1'b1 || usb_detach !== 1'b0) begin
            errors++;
            $display("FAIL reject_at_expiry: err=%b detach=%b expected 1/0", boot_err, usb_detach);
        end
        repeat (19) tick;
        checks++;
        if (usb_detach !== 1'b0) begin errors++; $display("FAIL reject_restart_early: detach=%b expected 0", usb_detach); end
        tick;
        checks++;
        if (usb_detach !== 1'b1 || warmboot_s !== 2'd1) begin
            errors++;
            $display("FAIL reject_restart_boot: detach=%b s=%0d expected 1/1", usb_detach, warmboot_s);
        end
    endtask

    task automatic test_ignore_busy;
        do_reset(1'b1);
        tick;
        boot_req = 1'b1; boot_image = 2'd2;
        tick;
        for (int i = 1; i <= 10; i++) begin
            boot_req   = (i <= 3);
            boot_image = 2'd0;
            checks++;
            if (usb_detach !== 1'b1 || warmboot_boot !== 1'b0 || warmboot_s !== 2'd2 || boot_err !== 1'b0) begin
                errors++;
                $display("FAIL ignore_busy cyc+%0d: detach=%b boot=%b s=%0d err=%b expected 1/0/2/0",
                         i, usb_detach, warmboot_boot, warmboot_s, boot_err);
            end
            tick;
        end
        boot_req = 1'b0;
        checks++;
        if (warmboot_boot !== 1'b1 || warmboot_s !== 2'd2) begin
            errors++;
            $display("FAIL ignore_busy_boot: boot=%b s=%0d expected 1/2", warmboot_boot, warmboot_s);
        end
    endtask

    task automatic test_reset_mid;
        do_reset(1'b1);
        tick;
        boot_req = 1'b1; boot_image = 2'd2;
        tick;
        boot_req = 1'b0;
        repeat (8) tick;
        checks++;
        if (usb_detach !== 1'b1 || warmboot_boot !== 1'b0) begin
            errors++;
            $display("FAIL mid_in_settle: detach=%b boot=%b expected 1/0", usb_detach, warmboot_boot);
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++;
        if (usb_detach !== 1'b0 || warmboot_boot !== 1'b0 || warmboot_s !== 2'd1 || boot_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_settle: detach=%b boot=%b s=%0d busy=%b expected 0/0/1/0",
                     usb_detach, warmboot_boot, warmboot_s, boot_busy);
        end
        boot_req = 1'b1; boot_image = 2'd0;
        tick;
        boot_req = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            checks++;
            if (usb_detach !== 1'b1 || warmboot_boot !== 1'b0 || warmboot_s !== 2'd0) begin
                errors++;
                $display("FAIL after_settle_reset cyc+%0d: detach=%b boot=%b s=%0d expected 1/0/0",
                         i, usb_detach, warmboot_boot, warmboot_s);
            end
            tick;
        end
        checks++;
        if (warmboot_boot !== 1'b1) begin errors++; $display("FAIL after_settle_reset_boot: got %b expected 1", warmboot_boot); end
        repeat (2) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++;
        if (usb_detach !== 1'b0 || warmboot_boot !== 1'b0 || warmboot_s !== 2'd1 || boot_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_boot: detach=%b boot=%b s=%0d busy=%b expected 0/0/1/0",
                     usb_detach, warmboot_boot, warmboot_s, boot_busy);
        end
        boot_req = 1'b1; boot_image = 2'd2;
        tick;
        boot_req = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            checks++;
            if (usb_detach !== 1'b1 || warmboot_boot !== 1'b0 || warmboot_s !== 2'd2) begin
                errors++;
                $display("FAIL after_boot_reset cyc+%0d: detach=%b boot=%b s=%0d expected 1/0/2",
                         i, usb_detach, warmboot_boot, warmboot_s);
            end
            tick;
        end
        checks++;
        if (warmboot_boot !== 1'b1) begin errors++; $display("FAIL after_boot_reset_boot: got %b expected 1", warmboot_boot); end
    endtask

    initial begin
        test_reset;
        test_normal_boot;
        test_bad_image;
        test_autoboot;
        test_activity_refresh;
        test_ignore_busy;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
